btn_press_conditioner: RTL
==========================

Name: btn_press_conditioner

Overview:
- Conditions the three raw player push-buttons into clean single-cycle press events for the game FSM.
- Performs synchronisation, press/release debouncing, multi-button rejection and comparison against the expected sequence number.
- Sits directly upstream of the game controller and replaces direct use of raw button levels.
- The controller consumes exactly one press_valid pulse per physical press.

Parameters:
- N_BTN, 3, number of player buttons; button i encodes sequence number i.
- DEBOUNCE_CYCLES, 50000, consecutive stable samples required to accept a press or release (1 ms at 50 MHz); must be >= 2.
- CNT_W, 16, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- enable  input  1  high while the controller is accepting player input
- btn_n  input  N_BTN  raw buttons, active-low (0 = pressed), asynchronous to clock
- expected  input  2  sequence number the controller currently expects (0..N_BTN-1)
- press_valid  output  1  one-cycle pulse: an accepted single-button press
- press_idx  output  2  index of the accepted button; valid while press_valid is high
- press_correct  output  1  press_idx == expected; valid while press_valid is high
- multi_press  output  1  one-cycle pulse: more than one button was held when the debounce completed
- pressed  output  1  high from acceptance until release is debounced (LED feedback)

Behaviour:
- Reset (reset == 0 at a clock edge):
  - Sync flops load all-released.
  - State goes to IDLE and cnt to 0.
  - press_valid, multi_press and pressed go to 0; press_idx and press_correct go to 0.
- Synchroniser: two flip-flop stages per bit. Internal level s = ~btn_n after two stages, so s bit i = 1 means button i is pressed.
- The synchroniser always runs, including while enable is low.
- Debounce FSM, one-hot or binary encoding free:
  - IDLE: if s != 0, latch cand <= s, cnt <= 0, go DB_PRESS.
  - DB_PRESS:
    - If s != cand, return to IDLE. No event.
    - Else cnt <= cnt+1.
    - When cnt == DEBOUNCE_CYCLES-1 with s == cand: go HELD and set pressed <= 1.
      - If cand is one-hot: press_valid <= 1, press_idx <= index of the set bit, press_correct <= (index == expected sampled that same cycle).
      - Otherwise: multi_press <= 1.
  - HELD: pressed stays 1. If s == 0, cnt <= 0 and go DB_RELEASE. Additional buttons pressed while in HELD are ignored; no new event.
  - DB_RELEASE:
    - If s != 0, return to HELD.
    - Else cnt <= cnt+1.
    - When cnt == DEBOUNCE_CYCLES-1: go IDLE and set pressed <= 0.
- Pulses:
  - press_valid and multi_press are registered and high for exactly one cycle.
  - They are never asserted together.
  - At most one event is produced per press/release cycle.
- Latency: the raw input becomes pressed and stays stable from edge t. press_valid is high in the cycle following edge t+DEBOUNCE_CYCLES+2, i.e. DEBOUNCE_CYCLES+3 edges after the raw change.
- press_idx and press_correct hold their last value until the next press_valid.
- expected values >= N_BTN never match, so press_correct = 0.
- enable low:
  - The FSM is forced to IDLE every cycle, with cnt = 0 and pressed = 0.
  - No pulses are generated.
  - When enable rises while a button is held, a full press debounce is required before press_valid; a stale press is never reported.
- Glitch rule: any s change during DB_PRESS restarts from IDLE, so a bounce shorter than DEBOUNCE_CYCLES never produces an event.
- Counter never wraps; the comparison against DEBOUNCE_CYCLES-1 stops it.
- Reset asserted mid-debounce or while HELD aborts with no pulse. After reset, a still-held button must be debounced afresh.

Test Plan (DEBOUNCE_CYCLES = 4):
- Reset, then btn_n = 3'b101 held with expected = 1 -> press_valid high for exactly 1 cycle, 7 edges after the change, with press_idx = 1, press_correct = 1, pressed = 1. Release -> pressed falls after 7 edges and no further pulse.
- btn_n = 3'b011 held with expected = 0 -> press_valid pulse with press_idx = 2 and press_correct = 0. Pressing button 0 additionally while held -> no event.
- Bounce: btn_n toggles 3'b111/3'b110 every 2 cycles for 20 cycles, then is stable 3'b110 -> exactly one press_valid with press_idx = 0, and none during the bouncing.
- btn_n = 3'b100 held (two buttons pressed) -> multi_press pulse of 1 cycle, press_valid stays 0. Releasing both, then pressing button 1 alone -> normal press_valid with press_idx = 1.
- enable = 0 while button 2 is held, then enable = 1 with the button still held -> press_valid with press_idx = 2, exactly 5 edges after enable rises (full debounce: DEBOUNCE_CYCLES+1, synchroniser already settled); no pulse while enable = 0.
- reset driven low during DB_PRESS, then high with the button still held -> no pulse at abort, one press_valid 7 edges after reset is released, all outputs 0 during reset.

Source files
------------

// File: rtl/btn_press_conditioner.sv
// rtl/btn_press_conditioner.sv - synchronise, debounce and qualify raw player buttons into single press events
module btn_press_conditioner #(
    parameter int N_BTN           = 3,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [N_BTN-1:0] btn_n,
    input  logic [1:0]       expected,
    output logic             press_valid,
    output logic [1:0]       press_idx,
    output logic             press_correct,
    output logic             multi_press,
    output logic             pressed
);

    typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_RELEASE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0] sync1, sync2, s;
    logic [N_BTN-1:0] cand, cand_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    state_t           state, state_nx;
    logic             pressed_nx, valid_nx, multi_nx, correct_nx;
    logic [1:0]       idx_nx, cand_idx;
    logic             cand_onehot;

    // raw buttons are active-low and asynchronous; s is the pressed mask after two stages
    assign s = ~sync2;

    assign cand_onehot = (cand != '0) && ((cand & (cand - N_BTN'(1))) == '0);

    always_comb begin
        cand_idx = 2'd0;
        for (int i = 0; i < N_BTN; i++) begin
            if (cand[i]) cand_idx = 2'(i);
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        cand_nx    = cand;
        pressed_nx = pressed;
        valid_nx   = 1'b0;
        multi_nx   = 1'b0;
        idx_nx     = press_idx;
        correct_nx = press_correct;
        if (!enable) begin
            // a press held across enable must be debounced again from scratch
            state_nx   = IDLE;
            cnt_nx     = '0;
            pressed_nx = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s != '0) begin
                        cand_nx  = s;
                        cnt_nx   = '0;
                        state_nx = DB_PRESS;
                    end
                end
                DB_PRESS: begin
                    if (s != cand) begin
                        state_nx = IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state_nx   = HELD;
                        pressed_nx = 1'b1;
                        if (cand_onehot) begin
                            valid_nx   = 1'b1;
                            idx_nx     = cand_idx;
                            correct_nx = (cand_idx == expected);
                        end else begin
                            multi_nx = 1'b1;
                        end
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (s == '0) begin
                        cnt_nx   = '0;
                        state_nx = DB_RELEASE;
                    end
                end
                DB_RELEASE: begin
                    if (s != '0) begin
                        state_nx = HELD;
                    end else if (cnt == CNT_LAST) begin
                        state_nx   = IDLE;
                        pressed_nx = 1'b0;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1         <= '1;
            sync2         <= '1;
            state         <= IDLE;
            cnt           <= '0;
            cand          <= '0;
            pressed       <= 1'b0;
            press_valid   <= 1'b0;
            multi_press   <= 1'b0;
            press_idx     <= 2'd0;
            press_correct <= 1'b0;
        end else begin
            sync1         <= btn_n;
            sync2         <= sync1;
            state         <= state_nx;
            cnt           <= cnt_nx;
            cand          <= cand_nx;
            pressed       <= pressed_nx;
            press_valid   <= valid_nx;
            multi_press   <= multi_nx;
            press_idx     <= idx_nx;
            press_correct <= correct_nx;
        end
    end

endmodule
